// File: rtl/mem_port_arbiter.sv
// Shares the unified memory between fetch and memory stage, one access at a time.
// Sequences the fixed memory latency and drives the pipeline stall lines.
module mem_port_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          write_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          pc_stall,
  output logic          ifid_stall,
  output logic          exmem_stall
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_last;
  logic       r_cancel;
  logic       r_we;

  logic w_idle;
  logic w_grant_d;
  logic w_issue;
  logic w_done;
  logic w_drop;

  assign w_idle    = (r_state == IDLE);
  // Data wins ties unless it won the previous tie-capable grant.
  assign w_grant_d = d_req & (~i_req | ~r_last);
  assign w_issue   = ~rst & w_idle & (i_req | d_req);
  assign w_done    = ~rst & ~w_idle & (r_cnt == 3'd0);
  assign w_drop    = (r_state == BUSY_I) ? ~i_req : ~d_req;

  assign i_valid    = w_done & (r_state == BUSY_I) & i_req & ~r_cancel;
  assign d_valid    = w_done & (r_state == BUSY_D) & d_req & ~r_cancel;
  assign write_done = d_valid & r_we;
  assign i_rdata    = mem_rdata;
  assign d_rdata    = mem_rdata;

  assign mem_en    = w_issue;
  assign mem_we    = w_issue & w_grant_d & d_we;
  assign mem_addr  = !w_issue ? '0 : (w_grant_d ? d_addr : i_addr);
  assign mem_wdata = (w_issue & w_grant_d) ? d_wdata : '0;

  assign pc_stall    = ~rst & i_req & ~i_valid;
  assign ifid_stall  = pc_stall;
  assign exmem_stall = ~rst & d_req & ~d_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_last   <= 1'b0;
      r_cancel <= 1'b0;
      r_we     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state  <= w_grant_d ? BUSY_D : BUSY_I;
            r_cnt    <= 3'(MEM_LAT - 1);
            r_last   <= w_grant_d;
            r_we     <= w_grant_d & d_we;
            r_cancel <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
            if (w_drop) r_cancel <= 1'b1;
          end else begin
            r_state  <= IDLE;
            r_cancel <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: timed stimulus per scenario plus a
// completion scoreboard fed by a latency-accurate memory model.
module tb_mem_port_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_valid;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          write_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          pc_stall;
  logic          ifid_stall;
  logic          exmem_stall;

  int vecs = 0;
  int errs = 0;

  typedef struct {
    bit          d;
    bit          we;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .write_done(write_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .exmem_stall(exmem_stall)
  );

  function automatic logic [15:0] rdfn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory model: read data valid exactly LAT cycles after issue.
  logic [15:0] pend_addr = '0;
  int          pend_cnt = 0;

  always @(posedge clk) begin
    if (mem_en) begin
      pend_addr <= mem_addr;
      pend_cnt  <= LAT;
    end else if (pend_cnt > 0) begin
      pend_cnt <= pend_cnt - 1;
    end
  end

  assign mem_rdata = (pend_cnt == 1) ? rdfn(pend_addr) : 16'hDEAD;

  always @(negedge clk) begin
    exp_t e;
    if (i_valid || d_valid) begin
      vecs++;
      if (i_valid && d_valid) begin
        errs++;
        $display("FAIL both_valid: i_valid and d_valid together at %0t", $time);
      end else if (q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_valid: i=%b d=%b, no completion expected", i_valid, d_valid);
      end else begin
        e = q.pop_front();
        if (d_valid !== e.d) begin
          errs++;
          $display("FAIL side: got d=%b want d=%b", d_valid, e.d);
        end else if (e.d && e.we) begin
          if (write_done !== 1'b1) begin
            errs++;
            $display("FAIL store_done: write_done=%b want 1", write_done);
          end
        end else if (e.d) begin
          if (d_rdata !== e.data || write_done !== 1'b0) begin
            errs++;
            $display("FAIL load_data: got %h wd=%b want %h wd=0", d_rdata, write_done, e.data);
          end
        end else if (i_rdata !== e.data) begin
          errs++;
          $display("FAIL fetch_data: got %h want %h", i_rdata, e.data);
        end
      end
    end else if (write_done) begin
      errs++;
      $display("FAIL stray_write_done: write_done=1 without d_valid");
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next();
    next();
    @(negedge clk);
    vecs++;
    if ({mem_en, mem_we, i_valid, d_valid, write_done,
         pc_stall, ifid_stall, exmem_stall} !== 8'h00) begin
      errs++;
      $display("FAIL reset_outs: got %b want 00000000",
               {mem_en, mem_we, i_valid, d_valid, write_done,
                pc_stall, ifid_stall, exmem_stall});
    end
    vecs++;
    if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
      errs++;
      $display("FAIL reset_bus: addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    next();
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    for (int k = 0; k < 4; k++) begin
      next();
      if (k == 0) begin
        i_req  = 1'b1;
        i_addr = 16'h0010;
        q.push_back('{d: 1'b0, we: 1'b0, data: rdfn(16'h0010)});
      end
      if (k == 3) i_req = 1'b0;
      @(negedge clk);
      vecs++;
      if (mem_en !== (k == 0)) begin
        errs++;
        $display("FAIL fetch_en k=%0d: got %b want %b", k, mem_en, k == 0);
      end
      if (k == 0) begin
        vecs++;
        if (mem_addr !== 16'h0010 || mem_we !== 1'b0) begin
          errs++;
          $display("FAIL fetch_issue: addr=%h we=%b want 0010 0", mem_addr, mem_we);
        end
      end
      vecs++;
      if (pc_stall !== (k < 2) || ifid_stall !== (k < 2)) begin
        errs++;
        $display("FAIL fetch_stall k=%0d: pc=%b ifid=%b want %b",
                 k, pc_stall, ifid_stall, k < 2);
      end
      vecs++;
      if (i_valid !== (k == 2)) begin
        errs++;
        $display("FAIL fetch_valid k=%0d: got %b want %b", k, i_valid, k == 2);
      end
    end
  endtask

  task automatic test_contention();
    rst = 1'b1;
    next();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      next();
      if (k == 0) begin
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0200;
        i_req  = 1'b1;
        i_addr = 16'h0012;
        q.push_back('{d: 1'b1, we: 1'b0, data: rdfn(16'h0200)});
        q.push_back('{d: 1'b0, we: 1'b0, data: rdfn(16'h0012)});
      end
      if (k == 3) d_req = 1'b0;
      if (k == 6) i_req = 1'b0;
      @(negedge clk);
      vecs++;
      if (mem_en !== (k == 0 || k == 3)) begin
        errs++;
        $display("FAIL cont_en k=%0d: got %b", k, mem_en);
      end
      if (k == 0 || k == 3) begin
        vecs++;
        if (mem_addr !== ((k == 0) ? 16'h0200 : 16'h0012)) begin
          errs++;
          $display("FAIL cont_addr k=%0d: got %h", k, mem_addr);
        end
      end
      vecs++;
      if (exmem_stall !== (k < 2) || pc_stall !== (k < 5)) begin
        errs++;
        $display("FAIL cont_stall k=%0d: ex=%b pc=%b want %b %b",
                 k, exmem_stall, pc_stall, k < 2, k < 5);
      end
    end
  endtask

  task automatic test_fairness();
    logic [15:0] want;
    for (int k = 0; k < 13; k++) begin
      next();
      if (k == 0) begin
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0400;
        i_req  = 1'b1;
        i_addr = 16'h0020;
        for (int n = 0; n < 2; n++) begin
          q.push_back('{d: 1'b1, we: 1'b0, data: rdfn(16'h0400)});
          q.push_back('{d: 1'b0, we: 1'b0, data: rdfn(16'h0020)});
        end
      end
      if (k == 12) begin
        d_req = 1'b0;
        i_req = 1'b0;
      end
      @(negedge clk);
      vecs++;
      if (mem_en !== (k < 12 && k % 3 == 0)) begin
        errs++;
        $display("FAIL fair_en k=%0d: got %b", k, mem_en);
      end
      if (k < 12 && k % 3 == 0) begin
        want = (k % 6 == 0) ? 16'h0400 : 16'h0020;
        vecs++;
        if (mem_addr !== want) begin
          errs++;
          $display("FAIL fair_order k=%0d: addr=%h want %h", k, mem_addr, want);
        end
      end
    end
  endtask

  task automatic test_store();
    for (int k = 0; k < 4; k++) begin
      next();
      if (k == 0) begin
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0300;
        d_wdata = 16'hBEEF;
        q.push_back('{d: 1'b1, we: 1'b1, data: 16'h0});
      end
      if (k == 1) d_wdata = 16'h1111;
      if (k == 3) begin
        d_req = 1'b0;
        d_we  = 1'b0;
      end
      @(negedge clk);
      if (k == 0) begin
        vecs++;
        if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 16'h0300 ||
            mem_wdata !== 16'hBEEF) begin
          errs++;
          $display("FAIL store_issue: en=%b we=%b addr=%h wd=%h want 1 1 0300 beef",
                   mem_en, mem_we, mem_addr, mem_wdata);
        end
      end else begin
        vecs++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
          errs++;
          $display("FAIL store_we_pulse k=%0d: en=%b we=%b want 0 0", k, mem_en, mem_we);
        end
      end
      vecs++;
      if (write_done !== (k == 2) || d_valid !== (k == 2)) begin
        errs++;
        $display("FAIL store_done k=%0d: wd=%b dv=%b want %b", k, write_done, d_valid, k == 2);
      end
    end
  endtask

  task automatic test_cancel();
    for (int k = 0; k < 7; k++) begin
      next();
      if (k == 0) begin
        i_req  = 1'b1;
        i_addr = 16'h0040;
      end
      if (k == 1) begin
        i_req  = 1'b0;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0050;
        q.push_back('{d: 1'b1, we: 1'b0, data: rdfn(16'h0050)});
      end
      if (k == 6) d_req = 1'b0;
      @(negedge clk);
      vecs++;
      if (mem_en !== (k == 0 || k == 3)) begin
        errs++;
        $display("FAIL cancel_en k=%0d: got %b", k, mem_en);
      end
      if (k == 2) begin
        vecs++;
        if (i_valid !== 1'b0 || exmem_stall !== 1'b1) begin
          errs++;
          $display("FAIL cancel_sup: iv=%b ex=%b want 0 1", i_valid, exmem_stall);
        end
      end
      if (k == 3) begin
        vecs++;
        if (mem_addr !== 16'h0050) begin
          errs++;
          $display("FAIL cancel_next: addr=%h want 0050", mem_addr);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 6; k++) begin
      next();
      if (k == 0) begin
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0060;
      end
      if (k == 1) rst = 1'b1;
      if (k == 2) begin
        rst    = 1'b0;
        d_req  = 1'b0;
        i_req  = 1'b1;
        i_addr = 16'h0070;
        q.push_back('{d: 1'b0, we: 1'b0, data: rdfn(16'h0070)});
      end
      if (k == 5) i_req = 1'b0;
      @(negedge clk);
      vecs++;
      if (d_valid !== 1'b0 || exmem_stall !== (k == 0)) begin
        errs++;
        $display("FAIL rmid_d k=%0d: dv=%b ex=%b", k, d_valid, exmem_stall);
      end
      if (k == 2) begin
        vecs++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0070) begin
          errs++;
          $display("FAIL rmid_issue: en=%b addr=%h want 1 0070", mem_en, mem_addr);
        end
      end
    end
    // Reset landing exactly on the completion cycle suppresses the pulse.
    for (int k = 0; k < 4; k++) begin
      next();
      if (k == 0) begin
        d_req  = 1'b1;
        d_we   = 1'b1;
        d_addr = 16'h0080;
      end
      rst = (k == 2);
      if (k == 3) begin
        d_req = 1'b0;
        d_we  = 1'b0;
      end
      @(negedge clk);
      vecs++;
      if (d_valid !== 1'b0 || write_done !== 1'b0) begin
        errs++;
        $display("FAIL rst_vs_done k=%0d: dv=%b wd=%b want 0 0", k, d_valid, write_done);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    test_reset();
    test_fetch();
    test_contention();
    test_fairness();
    test_store();
    test_cancel();
    test_reset_mid();
    next();
    next();
    vecs++;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_drain: %0d completions missing, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
